// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and encodings for the pipelined RV32I core:
//                forwarding selects, ALU/result encodings, control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Source of an execute-stage operand
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    // ALU operation encodings
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    // Writeback result source encodings
    localparam logic [1:0] c_res_alu = 2'b00;
    localparam logic [1:0] c_res_mem = 2'b01;
    localparam logic [1:0] c_res_pc4 = 2'b10;

    // Control bundle carried from decode to execute
    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic [2:0] alucontrol;
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic [1:0] resultsrc;
    } ctrl_t;

    // A bubble: no valid instruction, no side effects
    localparam ctrl_t c_ctrl_bubble = '0;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_unit
//  Description : Per-operand forwarding mux. Compares one source index against
//                the MEM and WB destinations and picks the youngest result.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rd_reg,
    input  logic                  regwrite_m,
    input  logic [ADDR_WIDTH-1:0] rdaddr_m,
    input  logic [DATA_WIDTH-1:0] aluresult_m,
    input  logic                  regwrite_w,
    input  logic [ADDR_WIDTH-1:0] rdaddr_w,
    input  logic [DATA_WIDTH-1:0] result_w,
    output fwd_sel_t              sel,
    output logic [DATA_WIDTH-1:0] data
);

    logic w_hit_m;
    logic w_hit_w;

    // x0 is hardwired zero, so a write to it must never be forwarded
    assign w_hit_m = regwrite_m && (rdaddr_m != '0) && (rdaddr_m == rs);
    assign w_hit_w = regwrite_w && (rdaddr_w != '0) && (rdaddr_w == rs);

    // MEM holds the younger result and therefore wins over WB
    always_comb begin
        sel  = FWD_NONE;
        data = rd_reg;
        if (w_hit_m) begin
            sel  = FWD_M;
            data = aluresult_m;
        end else if (w_hit_w) begin
            sel  = FWD_W;
            data = result_w;
        end
    end

endmodule : fwd_unit
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : Decode-to-execute pipeline register with stall, flush and
//                MEM/WB operand forwarding onto the ALU inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_d,
    input  logic [DATA_WIDTH-1:0] rd1_d,
    input  logic [DATA_WIDTH-1:0] rd2_d,
    input  logic [DATA_WIDTH-1:0] immext_d,
    input  logic [DATA_WIDTH-1:0] pc_d,
    input  logic [ADDR_WIDTH-1:0] rs1_d,
    input  logic [ADDR_WIDTH-1:0] rs2_d,
    input  logic [ADDR_WIDTH-1:0] rdaddr_d,
    input  logic                  alusrc_d,
    input  logic [2:0]            alucontrol_d,
    input  logic                  regwrite_d,
    input  logic                  memwrite_d,
    input  logic                  branch_d,
    input  logic [1:0]            resultsrc_d,
    input  logic                  regwrite_m,
    input  logic [ADDR_WIDTH-1:0] rdaddr_m,
    input  logic [DATA_WIDTH-1:0] aluresult_m,
    input  logic                  regwrite_w,
    input  logic [ADDR_WIDTH-1:0] rdaddr_w,
    input  logic [DATA_WIDTH-1:0] result_w,
    output logic [DATA_WIDTH-1:0] rd1_e,
    output logic [DATA_WIDTH-1:0] rd2_e,
    output logic [DATA_WIDTH-1:0] immext_e,
    output logic [DATA_WIDTH-1:0] pc_e,
    output logic [ADDR_WIDTH-1:0] rs1_e,
    output logic [ADDR_WIDTH-1:0] rs2_e,
    output logic [ADDR_WIDTH-1:0] rdaddr_e,
    output logic                  alusrc_e,
    output logic [2:0]            alucontrol_e,
    output logic                  regwrite_e,
    output logic                  memwrite_e,
    output logic                  branch_e,
    output logic [1:0]            resultsrc_e,
    output logic                  valid_e,
    output logic [1:0]            fwda_e,
    output logic [1:0]            fwdb_e
);

    ctrl_t                 w_ctrl_d;
    ctrl_t                 r_ctrl;
    logic [DATA_WIDTH-1:0] r_rd1;
    logic [DATA_WIDTH-1:0] r_rd2;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_rs1;
    logic [ADDR_WIDTH-1:0] r_rs2;
    logic [ADDR_WIDTH-1:0] r_rdaddr;
    fwd_sel_t              w_fwda;
    fwd_sel_t              w_fwdb;

    // An empty decode slot must not write anything, so its enables are gated
    always_comb begin
        w_ctrl_d            = c_ctrl_bubble;
        w_ctrl_d.valid      = valid_d;
        w_ctrl_d.alusrc     = alusrc_d;
        w_ctrl_d.alucontrol = alucontrol_d;
        w_ctrl_d.regwrite   = regwrite_d & valid_d;
        w_ctrl_d.memwrite   = memwrite_d & valid_d;
        w_ctrl_d.branch     = branch_d & valid_d;
        w_ctrl_d.resultsrc  = resultsrc_d;
    end

    // Pipeline register: flush beats stall beats capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl   <= c_ctrl_bubble;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_imm    <= '0;
            r_pc     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rdaddr <= '0;
        end else if (flush) begin
            r_ctrl   <= c_ctrl_bubble;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_imm    <= '0;
            r_pc     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rdaddr <= '0;
        end else if (!stall) begin
            r_ctrl   <= w_ctrl_d;
            r_rd1    <= rd1_d;
            r_rd2    <= rd2_d;
            r_imm    <= immext_d;
            r_pc     <= pc_d;
            r_rs1    <= rs1_d;
            r_rs2    <= rs2_d;
            r_rdaddr <= rdaddr_d;
        end
    end

    // Forwarding stays live during stalls: it depends only on held indices
    fwd_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd_a (
        .rs          (r_rs1),
        .rd_reg      (r_rd1),
        .regwrite_m  (regwrite_m),
        .rdaddr_m    (rdaddr_m),
        .aluresult_m (aluresult_m),
        .regwrite_w  (regwrite_w),
        .rdaddr_w    (rdaddr_w),
        .result_w    (result_w),
        .sel         (w_fwda),
        .data        (rd1_e)
    );

    fwd_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd_b (
        .rs          (r_rs2),
        .rd_reg      (r_rd2),
        .regwrite_m  (regwrite_m),
        .rdaddr_m    (rdaddr_m),
        .aluresult_m (aluresult_m),
        .regwrite_w  (regwrite_w),
        .rdaddr_w    (rdaddr_w),
        .result_w    (result_w),
        .sel         (w_fwdb),
        .data        (rd2_e)
    );

    assign fwda_e       = w_fwda;
    assign fwdb_e       = w_fwdb;
    assign immext_e     = r_imm;
    assign pc_e         = r_pc;
    assign rs1_e        = r_rs1;
    assign rs2_e        = r_rs2;
    assign rdaddr_e     = r_rdaddr;
    assign alusrc_e     = r_ctrl.alusrc;
    assign alucontrol_e = r_ctrl.alucontrol;
    assign regwrite_e   = r_ctrl.regwrite;
    assign memwrite_e   = r_ctrl.memwrite;
    assign branch_e     = r_ctrl.branch;
    assign resultsrc_e  = r_ctrl.resultsrc;
    assign valid_e      = r_ctrl.valid;

endmodule : id_ex_stage
`default_nettype wire
